// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 4-digit seven-segment scan controller with round-robin write arbiter
module sseg_scan_ctrl #(
    parameter int SHOW_CYC  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       wr_valid0,
    output logic       wr_ready0,
    input  logic [1:0] wr_digit0,
    input  logic [4:0] wr_code0,
    input  logic       wr_dp0,
    input  logic       wr_valid1,
    output logic       wr_ready1,
    input  logic [1:0] wr_digit1,
    input  logic [4:0] wr_code1,
    input  logic       wr_dp1,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    // A one-cycle interval still needs a 1-bit counter to compare against zero.
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    dig;

    logic [4:0]    code_mem [4];
    logic          dp_mem   [4];

    // Set when requester 1 won the most recent transfer; reset value favours requester 0.
    logic          last1;
    logic          fire0;
    logic          fire1;

    // Grants depend only on the valids and the round-robin pointer, never on the scan.
    assign wr_ready0 = wr_valid0 & (~wr_valid1 | last1);
    assign wr_ready1 = wr_valid1 & (~wr_valid0 | ~last1);
    assign fire0     = wr_valid0 & wr_ready0;
    assign fire1     = wr_valid1 & wr_ready1;

    // Active-low {a..g} pattern for a 5-bit code; codes 0x10 and up are blank.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'h00:   g = 7'b0000001;
            5'h01:   g = 7'b1001111;
            5'h02:   g = 7'b0010010;
            5'h03:   g = 7'b0000110;
            5'h04:   g = 7'b1001100;
            5'h05:   g = 7'b0100100;
            5'h06:   g = 7'b0100000;
            5'h07:   g = 7'b0001111;
            5'h08:   g = 7'b0000000;
            5'h09:   g = 7'b0000100;
            5'h0A:   g = 7'b0001000;
            5'h0B:   g = 7'b1100000;
            5'h0C:   g = 7'b0110001;
            5'h0D:   g = 7'b1000010;
            5'h0E:   g = 7'b0110000;
            5'h0F:   g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Digit storage and round-robin pointer; at most one transfer lands per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last1 <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                code_mem[i] <= 5'h10;
                dp_mem[i]   <= 1'b0;
            end
        end else if (fire0) begin
            code_mem[wr_digit0] <= wr_code0;
            dp_mem[wr_digit0]   <= wr_dp0;
            last1               <= 1'b0;
        end else if (fire1) begin
            code_mem[wr_digit1] <= wr_code1;
            dp_mem[wr_digit1]   <= wr_dp1;
            last1               <= 1'b1;
        end
    end

    // Scan FSM with registered pins; the pins always reflect the state held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            dig        <= 2'd0;
            an         <= 4'hF;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (en && (state == ST_SHOW)) begin
                an   <= ~(4'b0001 << dig);
                sseg <= {~dp_mem[dig], glyph(code_mem[dig])};
            end else begin
                an   <= 4'hF;
                sseg <= 8'hFF;
            end
            if (en) begin
                if (state == ST_BLANK) begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    if (cnt == SHOW_LAST) begin
                        state      <= ST_BLANK;
                        cnt        <= '0;
                        dig        <= dig + 2'd1;
                        frame_tick <= (dig == 2'd3);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;

    localparam int SHOW  = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = SHOW + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       wr_valid0 = 1'b0, wr_valid1 = 1'b0;
    logic       wr_ready0, wr_ready1;
    logic [1:0] wr_digit0 = 2'd0, wr_digit1 = 2'd0;
    logic [4:0] wr_code0 = 5'h00, wr_code1 = 5'h00;
    logic       wr_dp0 = 1'b0, wr_dp1 = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.SHOW_CYC(SHOW), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .reset(reset), .en(en),
        .wr_valid0(wr_valid0), .wr_ready0(wr_ready0), .wr_digit0(wr_digit0),
        .wr_code0(wr_code0), .wr_dp0(wr_dp0),
        .wr_valid1(wr_valid1), .wr_ready1(wr_ready1), .wr_digit1(wr_digit1),
        .wr_code1(wr_code1), .wr_dp1(wr_dp1),
        .an(an), .sseg(sseg), .frame_tick(frame_tick)
    );

    int tests = 0;
    int fails = 0;
    int pos = 0;
    int cyc = 0;
    int ft_prev = -1;
    int ft_last = -1;
    logic [4:0] m_code [4];
    logic       m_dp   [4];

    typedef struct {
        logic       v0;
        logic [1:0] d0;
        logic [4:0] c0;
        logic       p0;
        logic       v1;
        logic [1:0] d1;
        logic [4:0] c1;
        logic       p1;
        logic       r0;
        logic       r1;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [6:0] exp_glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'h00:   g = 7'b0000001;
            5'h01:   g = 7'b1001111;
            5'h02:   g = 7'b0010010;
            5'h03:   g = 7'b0000110;
            5'h04:   g = 7'b1001100;
            5'h05:   g = 7'b0100100;
            5'h06:   g = 7'b0100000;
            5'h07:   g = 7'b0001111;
            5'h08:   g = 7'b0000000;
            5'h09:   g = 7'b0000100;
            5'h0A:   g = 7'b0001000;
            5'h0B:   g = 7'b1100000;
            5'h0C:   g = 7'b0110001;
            5'h0D:   g = 7'b1000010;
            5'h0E:   g = 7'b0110000;
            5'h0F:   g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check grants, predict pins from scan position and model storage, advance.
    task automatic tick(input logic g0, input logic g1);
        logic [3:0] e_an;
        logic [7:0] e_sg;
        logic       e_ft;
        int d, q;
        #1;
        check("wr_ready0", 32'(wr_ready0), 32'(g0));
        check("wr_ready1", 32'(wr_ready1), 32'(g1));
        d = (pos / SLOT) % 4;
        q = pos % SLOT;
        if (!reset && en && q >= BLANK) begin
            e_an = ~(4'b0001 << d);
            e_sg = {~m_dp[d], exp_glyph(m_code[d])};
        end else begin
            e_an = 4'hF;
            e_sg = 8'hFF;
        end
        e_ft = !reset && en && (pos % FRAME == FRAME - 1);
        @(posedge clk);
        if (reset) begin
            pos = 0;
            for (int i = 0; i < 4; i++) begin
                m_code[i] = 5'h10;
                m_dp[i]   = 1'b0;
            end
        end else begin
            if (en) pos = (pos + 1) % FRAME;
            if (g0) begin
                m_code[wr_digit0] = wr_code0;
                m_dp[wr_digit0]   = wr_dp0;
            end else if (g1) begin
                m_code[wr_digit1] = wr_code1;
                m_dp[wr_digit1]   = wr_dp1;
            end
        end
        @(negedge clk);
        cyc++;
        check("an", 32'(an), 32'(e_an));
        check("sseg", 32'(sseg), 32'(e_sg));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        if (frame_tick === 1'b1) begin
            ft_prev = ft_last;
            ft_last = cyc;
        end
    endtask

    task automatic idle_to(input int target);
        for (int n = 0; n < 2 * FRAME && pos != target; n++) tick(1'b0, 1'b0);
        check("reach_pos", 32'(pos), 32'(target));
    endtask

    task automatic set_w0(input logic v, input logic [1:0] d, input logic [4:0] c, input logic p);
        wr_valid0 = v; wr_digit0 = d; wr_code0 = c; wr_dp0 = p;
    endtask

    task automatic set_w1(input logic v, input logic [1:0] d, input logic [4:0] c, input logic p);
        wr_valid1 = v; wr_digit1 = d; wr_code1 = c; wr_dp1 = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 4; i++) begin
            m_code[i] = 5'h10;
            m_dp[i]   = 1'b0;
        end

        // Contention table: requester 1 won last before row 1, so grants go 0,1,0,1.
        vecs[0] = '{1'b0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 5'h00, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'd2, 5'h04, 1'b0, 1'b1, 2'd3, 5'h05, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 2'd2, 5'h0C, 1'b0, 1'b1, 2'd3, 5'h05, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 2'd2, 5'h0C, 1'b0, 1'b1, 2'd3, 5'h0E, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 2'd2, 5'h09, 1'b1, 1'b1, 2'd3, 5'h0E, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 2'd2, 5'h09, 1'b1, 1'b0, 2'd0, 5'h00, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 2'd0, 5'h00, 1'b0, 1'b1, 2'd1, 5'h08, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 5'h00, 1'b0, 1'b0, 1'b0};

        // Reset and free-running scan with blank storage.
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("reset_an", 32'(an), 32'h0000000F);
        check("reset_sseg", 32'(sseg), 32'h000000FF);
        reset = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("first_an_low", 32'(an), 32'h0000000E);
        for (int i = 0; i < 45; i++) tick(1'b0, 1'b0);
        check("frame_spacing", 32'(ft_last - ft_prev), 32'(FRAME));

        // Write digit 1 = 8 with dp from requester 0, digit 0 = 1 from requester 1.
        set_w0(1'b1, 2'd1, 5'h08, 1'b1);
        tick(1'b1, 1'b0);
        set_w0(1'b0, 2'd0, 5'h00, 1'b0);
        set_w1(1'b1, 2'd0, 5'h01, 1'b0);
        tick(1'b0, 1'b1);
        set_w1(1'b0, 2'd0, 5'h00, 1'b0);
        idle_to(9);
        check("d1_an", 32'(an), 32'h0000000D);
        check("d1_sseg", 32'(sseg), 32'h00000000);
        idle_to(0);

        // Contention and arbitration table.
        for (int i = 0; i < 8; i++) begin
            set_w0(vecs[i].v0, vecs[i].d0, vecs[i].c0, vecs[i].p0);
            set_w1(vecs[i].v1, vecs[i].d1, vecs[i].c1, vecs[i].p1);
            tick(vecs[i].r0, vecs[i].r1);
        end
        idle_to(15);
        check("d2_sseg", 32'(sseg), 32'h00000004);
        check("d2_an", 32'(an), 32'h0000000B);
        idle_to(21);
        check("d3_sseg", 32'(sseg), 32'h000000B0);
        check("d3_an", 32'(an), 32'h00000007);

        // Live update of digit 0 while it is showing.
        idle_to(3);
        check("live_old", 32'(sseg), 32'h000000CF);
        set_w0(1'b1, 2'd0, 5'h0F, 1'b0);
        tick(1'b1, 1'b0);
        set_w0(1'b0, 2'd0, 5'h00, 1'b0);
        check("live_hs_cycle", 32'(sseg), 32'h000000CF);
        tick(1'b0, 1'b0);
        check("live_new", 32'(sseg), 32'h000000B8);
        check("live_an", 32'(an), 32'h0000000E);

        // Enable pause midway through digit 2.
        idle_to(16);
        en = 1'b0;
        tick(1'b0, 1'b0);
        check("pause_an", 32'(an), 32'h0000000F);
        check("pause_sseg", 32'(sseg), 32'h000000FF);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0);
        en = 1'b1;
        tick(1'b0, 1'b0);
        check("resume_an", 32'(an), 32'h0000000B);
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            tick(1'b0, 1'b0);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        check("pause_frame_spacing", 32'(ft_last - ft_prev), 32'(FRAME + 10));

        // Reset during digit 3 with requester 0 held and losing arbitration.
        idle_to(21);
        set_w0(1'b1, 2'd3, 5'h05, 1'b0);
        set_w1(1'b1, 2'd2, 5'h07, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b1);
        reset = 1'b0;
        set_w0(1'b0, 2'd0, 5'h00, 1'b0);
        set_w1(1'b0, 2'd0, 5'h00, 1'b0);
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_sseg", 32'(sseg), 32'h000000FF);
        check("rst_frame_tick", 32'(frame_tick), 32'h00000000);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("rst_restart_an", 32'(an), 32'h0000000E);
        check("rst_blank_sseg", 32'(sseg), 32'h000000FF);
        idle_to(0);

        // Round-robin pointer favours requester 0 again after reset.
        set_w0(1'b1, 2'd1, 5'h03, 1'b0);
        set_w1(1'b1, 2'd2, 5'h02, 1'b0);
        tick(1'b1, 1'b0);
        set_w0(1'b0, 2'd0, 5'h00, 1'b0);
        tick(1'b0, 1'b1);
        set_w1(1'b0, 2'd0, 5'h00, 1'b0);
        idle_to(9);
        check("post_rst_d1", 32'(sseg), 32'h00000086);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
